axis_result_packer: RTL and testbench

- Upstream feeder of the AXIS master/FIFO output stage.
- Collects the 1-bit binarised results of the final BNN layer.
- Packs the results LSB-first into 32-bit words and drives the master's data/valid/last inputs.
- Marks the final word of each inference frame with TLAST so the DMA transfer terminates correctly.

---
 rtl/axis_result_packer.sv | 87 ++++++++
 tb/tb_axis_result_packer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/axis_result_packer.sv
// axis_result_packer: packs 1-bit BNN results LSB-first into DATA_WIDTH-bit AXIS words, TLAST on frame end.
// Define PACKER_HEADER_EN to prepend a {frame_cnt, frame_len} header word to every frame.
module axis_result_packer #(
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  M_AXIS_ACLK,
    input  logic                  M_AXIS_ARESETN,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  frame_len,
    input  logic                  bit_in,
    input  logic                  bit_valid,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] TDATA_out,
    output logic                  TVALID_out,
    output logic                  TLAST_out
);
    localparam int PW = $clog2(DATA_WIDTH);

    typedef enum logic {IDLE, PACK} state_t;

    state_t                state, state_n;
    logic [DATA_WIDTH-1:0] acc, acc_n;
    logic [PW-1:0]         word_pos;
    logic [LEN_WIDTH-1:0]  bit_cnt, len_q;
    logic                  launch, accept, last_bit, emit;
`ifdef PACKER_HEADER_EN
    logic [15:0]           frame_cnt;
`endif

    always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
        if (!M_AXIS_ARESETN) state <= IDLE;
        else                 state <= state_n;
    end

    always_comb begin
        acc_n    = acc;
        launch   = state == IDLE && start && frame_len != '0;
        accept   = state == PACK && bit_valid;
        last_bit = accept && bit_cnt == len_q - LEN_WIDTH'(1);
        emit     = last_bit || (accept && word_pos == PW'(DATA_WIDTH - 1));
        if (accept) acc_n[word_pos] = bit_in;
        state_n  = launch ? PACK : last_bit ? IDLE : state;
    end

    always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
        if (!M_AXIS_ARESETN) begin
            TDATA_out  <= '0;
            TVALID_out <= 1'b0;
            TLAST_out  <= 1'b0;
            done       <= 1'b0;
            acc        <= '0;
            word_pos   <= '0;
            bit_cnt    <= '0;
            len_q      <= '0;
`ifdef PACKER_HEADER_EN
            frame_cnt  <= '0;
`endif
        end else begin
            TVALID_out <= emit;
            TLAST_out  <= last_bit;
            done       <= last_bit;
            acc        <= emit ? '0 : acc_n;
            if (emit) TDATA_out <= acc_n;
            if (launch) begin
                len_q    <= frame_len;
                bit_cnt  <= '0;
                word_pos <= '0;
            end else if (accept) begin
                bit_cnt  <= bit_cnt + LEN_WIDTH'(1);
                word_pos <= emit ? '0 : word_pos + PW'(1);
            end
`ifdef PACKER_HEADER_EN
            // Header lands the cycle after start; data bits cannot complete a word that early.
            if (launch) begin
                TDATA_out  <= DATA_WIDTH'({frame_cnt, frame_len});
                TVALID_out <= 1'b1;
            end
            if (last_bit) frame_cnt <= frame_cnt + 16'd1;
`endif
        end
    end

    assign busy = state == PACK;

endmodule

// File: tb/tb_axis_result_packer.sv
// tb_axis_result_packer: randomized directed bench for axis_result_packer against a word-chunking reference model.
module tb_axis_result_packer;
    localparam int DW = 32;
    localparam int LW = 16;

    typedef struct {
        logic [31:0] d;
        logic        l;
        int          c;
    } wd_t;

    logic          M_AXIS_ACLK = 1'b0;
    logic          M_AXIS_ARESETN = 1'b0;
    logic          start = 1'b0;
    logic [LW-1:0] frame_len = '0;
    logic          bit_in = 1'b0;
    logic          bit_valid = 1'b0;
    logic          busy, done, TVALID_out, TLAST_out;
    logic [DW-1:0] TDATA_out;

    axis_result_packer #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
        .M_AXIS_ACLK   (M_AXIS_ACLK),
        .M_AXIS_ARESETN(M_AXIS_ARESETN),
        .start         (start),
        .frame_len     (frame_len),
        .bit_in        (bit_in),
        .bit_valid     (bit_valid),
        .busy          (busy),
        .done          (done),
        .TDATA_out     (TDATA_out),
        .TVALID_out    (TVALID_out),
        .TLAST_out     (TLAST_out)
    );

    always #5 M_AXIS_ACLK = ~M_AXIS_ACLK;

    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;
    int          proto_err = 0;
    int          model_fc = 0;
    logic [31:0] prev_d = '0;
    logic [31:0] last_word = '0;
    logic        stim_bits[$];
    wd_t         got[$];
    wd_t         exp_q[$];

    always @(posedge M_AXIS_ACLK) cyc <= cyc + 1;

    // Output monitor: captures every valid word and flags hold/TLAST/done protocol breaks.
    always @(negedge M_AXIS_ACLK) begin
        if (!M_AXIS_ARESETN) prev_d = '0;
        else begin
            if (TVALID_out) begin
                got.push_back('{TDATA_out, TLAST_out, cyc});
                if (TLAST_out) last_word = TDATA_out;
            end else if (TDATA_out !== prev_d || TLAST_out !== 1'b0) proto_err++;
            if (done !== (TVALID_out & TLAST_out)) proto_err++;
            prev_d = TDATA_out;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic compare();
        int n;
        check("word_count", 64'(got.size()), 64'(exp_q.size()));
        n = got.size() < exp_q.size() ? got.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check("tdata", 64'(got[i].d), 64'(exp_q[i].d));
            check("tlast", 64'(got[i].l), 64'(exp_q[i].l));
            check("latency", 64'(got[i].c), 64'(exp_q[i].c));
        end
        check("protocol", 64'(proto_err), 64'd0);
        got.delete();
        exp_q.delete();
    endtask

    task automatic begin_frame(input int len);
        @(posedge M_AXIS_ACLK); #1;
        start = 1'b1;
        frame_len = len[LW-1:0];
`ifdef PACKER_HEADER_EN
        exp_q.push_back('{{model_fc[15:0], len[15:0]}, 1'b0, cyc + 1});
`endif
        @(posedge M_AXIS_ACLK); #1;
        start = 1'b0;
    endtask

    // Drives stim_bits as one frame; expected words are 32-bit LSB-first chunks of the bit list.
    task automatic run_frame(input int len, input int gap_lo, input int gap_hi, input bit poke);
        logic [31:0] w;
        w = '0;
        begin_frame(len);
        for (int i = 0; i < len; i++) begin
            repeat ($urandom_range(gap_lo, gap_hi)) begin
                @(posedge M_AXIS_ACLK); #1;
            end
            check("busy_in_frame", 64'(busy), 64'd1);
            bit_valid = 1'b1;
            bit_in = stim_bits[i];
            if (poke && i == len / 2) begin
                start = 1'b1;
                frame_len = LW'($urandom_range(1, 200));
            end
            w[i % 32] = stim_bits[i];
            if (i % 32 == 31 || i == len - 1) begin
                exp_q.push_back('{w, i == len - 1, cyc + 1});
                w = '0;
            end
            @(posedge M_AXIS_ACLK); #1;
            bit_valid = 1'b0;
            start = 1'b0;
        end
        model_fc++;
        repeat (3) @(posedge M_AXIS_ACLK);
        #1;
        check("busy_after", 64'(busy), 64'd0);
        compare();
    endtask

    task automatic fill_random(input int len);
        stim_bits.delete();
        for (int i = 0; i < len; i++) stim_bits.push_back(1'($urandom_range(0, 1)));
    endtask

    initial begin
        logic [31:0] pat;
        int          len;
        #1;
        check("rst_tvalid", 64'(TVALID_out), 64'd0);
        check("rst_tdata", 64'(TDATA_out), 64'd0);
        check("rst_tlast", 64'(TLAST_out), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        repeat (2) @(posedge M_AXIS_ACLK);
        #1 M_AXIS_ARESETN = 1'b1;

        // Reset mid-frame: 10 of 40 bits, then reset; no data word may appear.
        fill_random(10);
        begin_frame(40);
        for (int i = 0; i < 10; i++) begin
            bit_valid = 1'b1;
            bit_in = stim_bits[i];
            @(posedge M_AXIS_ACLK); #1;
        end
        bit_valid = 1'b0;
        #2 M_AXIS_ARESETN = 1'b0;
        #1;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_tdata", 64'(TDATA_out), 64'd0);
        check("midrst_tvalid", 64'(TVALID_out), 64'd0);
        repeat (2) @(posedge M_AXIS_ACLK);
        #1 M_AXIS_ARESETN = 1'b1;
        model_fc = 0;
        compare();
        stim_bits = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        run_frame(8, 0, 0, 1'b0);
        check("restart_word", 64'(last_word), 64'h4D);

        // Exact 32-bit frame.
        pat = 32'hA5A5A5A5;
        stim_bits.delete();
        for (int i = 0; i < 32; i++) stim_bits.push_back(pat[i]);
        run_frame(32, 0, 0, 1'b0);
        check("exact_word", 64'(last_word), 64'hA5A5A5A5);

        // Partial final word.
        stim_bits.delete();
        for (int i = 0; i < 35; i++) stim_bits.push_back(1'b1);
        run_frame(35, 0, 0, 1'b0);
        check("partial_word", 64'(last_word), 64'h7);

        // Gapped input, one bit every third cycle.
        stim_bits = '{1'b1, 1'b1, 1'b0};
        run_frame(3, 2, 2, 1'b0);
        check("gapped_word", 64'(last_word), 64'h3);

        // Ignored inputs while idle: bit_valid and a zero-length start.
        for (int i = 0; i < 5; i++) begin
            bit_valid = 1'b1;
            bit_in = 1'($urandom_range(0, 1));
            @(posedge M_AXIS_ACLK); #1;
        end
        bit_valid = 1'b0;
        start = 1'b1;
        frame_len = '0;
        @(posedge M_AXIS_ACLK); #1;
        start = 1'b0;
        repeat (3) @(posedge M_AXIS_ACLK);
        #1;
        check("idle_busy", 64'(busy), 64'd0);
        compare();

        // Start pulsed mid-frame must not disturb the frame.
        fill_random(45);
        run_frame(45, 0, 1, 1'b1);

        // Randomized frames.
        for (int f = 0; f < 6; f++) begin
            len = $urandom_range(1, 100);
            fill_random(len);
            run_frame(len, 0, 2, 1'($urandom_range(0, 1)));
        end

        // Two single-bit frames (header counter check when headers are enabled).
        stim_bits = '{1'b1};
        run_frame(1, 0, 0, 1'b0);
        run_frame(1, 0, 0, 1'b0);
        check("single_bit_word", 64'(last_word), 64'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
